// File: rtl/wb_load_stage_pkg.sv
// rtl/wb_load_stage_pkg.sv - shared constants and types for the writeback/load stage
package wb_load_stage_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/wb_load_stage_load_extract.sv
// rtl/wb_load_stage_load_extract.sv - load size decode, byte/half lane select and extension
module wb_load_stage_load_extract
  import wb_load_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = addr_lo[0];
      end
      F3_LW:  misaligned = (addr_lo != 2'd0);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_load_stage.sv
// rtl/wb_load_stage.sv - writeback stage: registered RF write, load wait with timeout
module wb_load_stage
  import wb_load_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  load_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            addr_q, addr_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  load_err_q, load_err_d;

  logic                  accept;
  logic                  wait_timeout;
  logic                  load_bad;
  logic [2:0]            ext_funct3;
  logic [1:0]            ext_addr;
  logic [XLEN-1:0]       ext_data;
  logic                  ext_misaligned;
  logic                  ext_illegal;

  assign in_ready = rst_n && (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  // One decoder serves both phases: incoming fields in IDLE, captured fields in WAIT.
  assign ext_funct3 = (state_q == WAIT) ? f3_q   : in_funct3;
  assign ext_addr   = (state_q == WAIT) ? addr_q : in_addr_lo;
  assign load_bad   = ext_misaligned || ext_illegal;

  wb_load_stage_load_extract #(.XLEN(XLEN)) u_extract (
    .funct3     (ext_funct3),
    .addr_lo    (ext_addr),
    .rdata      (mem_rdata),
    .data       (ext_data),
    .misaligned (ext_misaligned),
    .illegal    (ext_illegal)
  );

  // A response on the timeout edge takes priority, so the timeout is qualified by !mem_rvalid.
  assign wait_timeout = (state_q == WAIT) && !mem_rvalid &&
                        (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rd_we_q    <= rd_we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && in_is_load && !load_bad) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid || wait_timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    load_err_d = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rd_d       = rd_q;
    rd_we_d    = rd_we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    if (accept) begin
      if (!in_is_load) begin
        rf_we_d    = in_rd_we && (in_rd != '0);
        rf_waddr_d = in_rd;
        rf_wdata_d = in_result;
      end else if (load_bad) begin
        load_err_d = 1'b1;
      end else begin
        rd_d    = in_rd;
        rd_we_d = in_rd_we;
        f3_d    = in_funct3;
        addr_d  = in_addr_lo;
      end
    end else if (state_q == WAIT) begin
      if (mem_rvalid) begin
        rf_we_d    = rd_we_q && (rd_q != '0);
        rf_waddr_d = rd_q;
        rf_wdata_d = ext_data;
      end else if (wait_timeout) begin
        load_err_d = 1'b1;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_wb_load_stage.sv
// tb/tb_wb_load_stage.sv - directed and randomized checks of wb_load_stage against a reference model
module tb_wb_load_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  wb_load_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_result  (in_result),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: shift the addressed lane down, then extend by arithmetic on its numeric value.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> (32'(a) * 8);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return a != 0;
      default:    return 1'b1;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_rd      = '0;
    in_rd_we   = 1'b0;
    in_is_load = 1'b0;
    in_funct3  = '0;
    in_addr_lo = '0;
    in_result  = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_nonload(input logic [4:0] rd, input logic we, input logic [31:0] res, input string tag);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_rd_we   = we;
    in_result  = res;
    in_funct3  = 3'($urandom);
    in_addr_lo = 2'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".we"}, rf_we, we && (rd != 0));
    chk({tag, ".err"}, load_err, 0);
    chk({tag, ".waddr"}, rf_waddr, rd);
    chk({tag, ".wdata"}, rf_wdata, res);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd, input logic we,
                         input logic [31:0] w, input int delay, input string tag);
    logic exp_we;
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_funct3  = f3;
    in_addr_lo = a;
    in_rd      = rd;
    in_rd_we   = we;
    in_result  = $urandom;
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b0;
    if (ref_bad(f3, a)) begin
      chk({tag, ".err"}, load_err, 1);
      chk({tag, ".err_we"}, rf_we, 0);
      chk({tag, ".err_ready"}, in_ready, 1);
      return;
    end
    chk({tag, ".wait_ready"}, in_ready, 0);
    chk({tag, ".wait_we"}, rf_we, 0);
    chk({tag, ".wait_err"}, load_err, 0);
    repeat (delay) begin
      @(posedge clk); #1;
      chk({tag, ".stall"}, in_ready, 0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = w;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    exp_we = we && (rd != 0);
    chk({tag, ".we"}, rf_we, exp_we);
    chk({tag, ".err0"}, load_err, 0);
    chk({tag, ".ready"}, in_ready, 1);
    if (exp_we) begin
      chk({tag, ".waddr"}, rf_waddr, rd);
      chk({tag, ".wdata"}, rf_wdata, ref_load(f3, a, w));
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst.ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we", rf_we, 0);
    chk("rst.waddr", rf_waddr, 0);
    chk("rst.wdata", rf_wdata, 0);
    chk("rst.err", load_err, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready_after", in_ready, 1);

    do_nonload(5'd5, 1'b1, 32'hDEADBEEF, "nl_rd5");
    do_nonload(5'd0, 1'b1, 32'h12345678, "nl_rd0");
    do_nonload(5'd3, 1'b1, 32'h00000001, "nl_b2b_a");
    do_nonload(5'd4, 1'b1, 32'h00000002, "nl_b2b_b");
    do_nonload(5'd6, 1'b0, 32'hCAFEF00D, "nl_nowe");

    do_load(3'b001, 2'd2, 5'd7, 1'b1, 32'h80011234, 1, "lh");
    do_load(3'b101, 2'd2, 5'd7, 1'b1, 32'h80011234, 1, "lhu");
    do_load(3'b000, 2'd1, 5'd8, 1'b1, 32'h00008000, 0, "lb");
    do_load(3'b100, 2'd3, 5'd9, 1'b1, 32'hAB000000, 2, "lbu");
    do_load(3'b010, 2'd0, 5'd10, 1'b1, 32'h13579BDF, 0, "lw");
    do_load(3'b010, 2'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 1, "lw_rd0");
    do_load(3'b001, 2'd1, 5'd11, 1'b1, 32'h0, 0, "lh_mis");
    do_load(3'b011, 2'd0, 5'd11, 1'b1, 32'h0, 0, "f3_011");
    do_load(3'b010, 2'd2, 5'd11, 1'b1, 32'h0, 0, "lw_mis");
    do_load(3'b000, 2'd0, 5'd12, 1'b1, 32'h0000007F, TO - 1, "rvalid_at_timeout");

    // Timeout: count WAIT cycles with no response.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_funct3  = 3'b010;
    in_addr_lo = 2'd0;
    in_rd      = 5'd13;
    in_rd_we   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      chk("to.no_early_err", load_err, 0);
      @(posedge clk); #1;
      n++;
    end
    chk("to.wait_cycles", n, TO);
    chk("to.err", load_err, 1);
    chk("to.we", rf_we, 0);
    chk("to.ready", in_ready, 1);
    @(posedge clk); #1;
    chk("to.err_pulse", load_err, 0);

    // Reset while a load is outstanding, then a stale response.
    do_nonload(5'd14, 1'b1, 32'hA5A5A5A5, "pre_rst");
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_funct3  = 3'b010;
    in_addr_lo = 2'd0;
    in_rd      = 5'd15;
    in_rd_we   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst.ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mrst.we", rf_we, 0);
    chk("mrst.waddr", rf_waddr, 0);
    chk("mrst.wdata", rf_wdata, 0);
    chk("mrst.err", load_err, 0);
    chk("mrst.ready", in_ready, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("mrst.late_we", rf_we, 0);
    chk("mrst.late_err", load_err, 0);
    do_nonload(5'd9, 1'b1, 32'h0BADF00D, "post_rst");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0)
        do_nonload(5'($urandom), 1'($urandom), $urandom, "rnd_nl");
      else
        do_load(3'($urandom), 2'($urandom), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                $urandom, int'($urandom_range(0, 4)), "rnd_ld");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_load_stage.md
Name: wb_load_stage

Overview:
Writeback stage directly upstream of the register file write port (we/waddr/wdata).
- Accepts one retiring instruction per handshake from the memory stage.
- For loads, waits for the data-memory response, then extracts, aligns and sign/zero-extends the data (LB/LBU/LH/LHU/LW).
- Drives a registered one-cycle write pulse into the register file; stalls upstream while a load is outstanding.

Parameters:
XLEN, 32, datapath width (only 32 supported)
TIMEOUT, 16, max cycles spent in WAIT before a load is abandoned (≥2)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept; = rst_n && state==IDLE (combinational)
in_rd  in  5  destination register
in_rd_we  in  1  instruction writes rd
in_is_load  in  1  instruction is a load
in_funct3  in  3  load size/sign (RV32I encoding)
in_addr_lo  in  2  load byte address [1:0]
in_result  in  32  ALU/non-load writeback value
mem_rvalid  in  1  data-memory read response valid
mem_rdata  in  32  data-memory read word (word-aligned)
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
load_err  out  1  one-cycle pulse: misaligned/illegal load or timeout

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, timeout counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0. Applies mid-WAIT: outstanding load dropped, no write, no err.
- All outputs except in_ready are registered. rf_we and load_err are single-cycle pulses, never both high.
- Accept = in_valid && in_ready.
- Non-load accepted at edge N: at N+1, rf_we = in_rd_we && (in_rd!=0), rf_waddr=in_rd, rf_wdata=in_result. Latency 1. Back-to-back accepts yield back-to-back writes.
- Load funct3 decode:
  - 000 LB: byte at addr_lo*8, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at addr_lo[1]*16, sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: full word.
  - 011/110/111: illegal.
- Misaligned load: LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
- Illegal or misaligned load accepted at N: no WAIT; at N+1, load_err=1, rf_we=0.
- Legal load accepted at N: capture rd, rd_we, funct3, addr_lo; state IDLE→WAIT; counter cleared.
- mem_rvalid in the accept cycle or while IDLE is ignored.
- WAIT, mem_rvalid=1 at edge M:
  - at M+1, rf_we = rd_we && rd!=0, rf_wdata = extracted value; state→IDLE.
  - in_ready high again during cycle M+1.
- WAIT, no mem_rvalid: counter increments each cycle.
  - At the edge where it reaches TIMEOUT: load_err pulses next cycle, rf_we=0, state→IDLE.
  - If mem_rvalid and the timeout coincide on the same edge, the response wins.
- FSM: IDLE→WAIT (legal load accepted); WAIT→IDLE (rvalid or timeout); any→IDLE on reset.
- rd=0 never produces rf_we=1, even for loads.

Decomposition:
- Shared package:
  - funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - State enum {IDLE, WAIT}.
  - REG_ADDR_W=5.
- One natural sub-module: load_extract.
  - Purely combinational.
  - Inputs: funct3, addr_lo, rdata. Outputs: data, misaligned, illegal.
  - The same decode is reused at accept time for the error check.

Test Plan:
- Non-load rd=5, result=0xDEADBEEF accepted at cycle 1 → cycle 2: rf_we=1, waddr=5, wdata=0xDEADBEEF; rd=0 variant → rf_we=0.
- LH, addr_lo=2, rd=7; mem_rdata=0x8001_1234 two cycles later → in_ready=0 while waiting; rf_we=1, wdata=0xFFFF8001 one cycle after rvalid. LHU same → 0x00008001.
- LB addr_lo=1, rdata=0x0000_8000 → 0xFFFFFF80; LBU addr_lo=3, rdata=0xAB00_0000 → 0x000000AB; LW addr_lo=0 → rdata unchanged.
- LH with addr_lo=1, and funct3=011 → load_err pulse next cycle, rf_we=0, never enters WAIT, in_ready stays 1.
- Legal load with no rvalid → exactly TIMEOUT(16) cycles in WAIT, then load_err=1, rf_we=0, in_ready=1.
- Reset asserted for one cycle mid-WAIT, then late rvalid → outputs 0, rvalid ignored, no write; next non-load completes with latency 1.
